// File: rtl/cs_pkg.sv
// cs_pkg: shared widths, FSM state type and the shift-add x9 helper for the CS sequencer.
package cs_pkg;
   localparam int X_W   = 8;
   localparam int WIN   = 9;
   localparam int Y_W   = X_W + 2;
   localparam int SUM_W = X_W + 4;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   typedef logic [3:0] idx_t;

   function automatic logic [SUM_W-1:0] times9(input logic [X_W-1:0] w);
      return (SUM_W'(w) << 3) + SUM_W'(w);
   endfunction
endpackage

// File: rtl/cs_window.sv
// cs_window: 9-entry circular sample window with fill count, running sum and one read port.
module cs_window
   import cs_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_we,
   input  logic             i_clr,
   input  logic [X_W-1:0]   i_x,
   input  idx_t             i_idx,
   output logic [SUM_W-1:0] o_sum,
   output logic [3:0]       o_count,
   output logic [X_W-1:0]   o_rd
);
   logic [X_W-1:0]   r_win [WIN];
   idx_t             r_wr_ptr;
   logic [3:0]       r_count;
   logic [SUM_W-1:0] r_sum;

   // The evicted slot is still 0 during fill, so the sum update needs no special case.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < WIN; i++) r_win[i] <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_sum    <= '0;
      end else if (i_clr) begin
         for (int i = 0; i < WIN; i++) r_win[i] <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_sum    <= '0;
      end else if (i_we) begin
         r_win[r_wr_ptr] <= i_x;
         r_sum    <= r_sum - SUM_W'(r_win[r_wr_ptr]) + SUM_W'(i_x);
         r_wr_ptr <= (r_wr_ptr == idx_t'(WIN - 1)) ? '0 : r_wr_ptr + 4'd1;
         r_count  <= (r_count == 4'(WIN)) ? r_count : r_count + 4'd1;
      end
   end

   assign o_sum   = r_sum;
   assign o_count = r_count;
   assign o_rd    = r_win[i_idx];
endmodule

// File: rtl/cs_seq.sv
// cs_seq: handshaked CS sliding-window sequencer; serial 9-cycle scan finds largest Xi <= sum/9.
// Optional flush input when CS_SEQ_FLUSH_EN is defined.
module cs_seq
   import cs_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic [X_W-1:0] X,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [Y_W-1:0] Y,
   output logic           out_valid,
   input  logic           out_ready
`ifdef CS_SEQ_FLUSH_EN
   ,
   input  logic           flush
`endif
);
   state_t           r_state;
   idx_t             r_idx;
   logic [X_W-1:0]   r_xappr;
   logic             w_flush;
   logic             w_accept;
   logic             w_take;
   logic [X_W-1:0]   w_rd;
   logic [X_W-1:0]   w_xnext;
   logic [SUM_W-1:0] w_sum;
   logic [3:0]       w_count;

`ifdef CS_SEQ_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   assign in_ready = (r_state == IDLE) && !w_flush;
   assign w_accept = in_valid && in_ready;
   // 9*Xi <= sum replaces the divide by 9
   assign w_take   = (times9(w_rd) <= w_sum) && (w_rd > r_xappr);
   assign w_xnext  = w_take ? w_rd : r_xappr;

   cs_window u_window (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_accept),
      .i_clr   (w_flush),
      .i_x     (X),
      .i_idx   (r_idx),
      .o_sum   (w_sum),
      .o_count (w_count),
      .o_rd    (w_rd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_xappr   <= '0;
         Y         <= '0;
         out_valid <= 1'b0;
      end else if (w_flush) begin
         r_state   <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_accept && w_count >= 4'd8) begin
               r_state <= SCAN;
               r_idx   <= '0;
               r_xappr <= '0;
            end
            SCAN: begin
               r_xappr <= w_xnext;
               if (r_idx == idx_t'(WIN - 1)) begin
                  Y         <= Y_W'(({1'b0, w_sum} + {1'b0, times9(w_xnext)}) >> 3);
                  out_valid <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_idx <= r_idx + 4'd1;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/cs_seq.md
# cs_seq

Sequencer for the CS sliding-window approximation datapath. It accepts 8-bit samples over a valid/ready handshake into a 9-entry circular window with a running sum. After each sample that leaves the window full, it serially scans the window for the approximate value and returns one 10-bit result over a valid/ready handshake. It replaces the free-running one-sample-per-cycle CS front end where the producer or consumer can stall.

## Interface
- X_W, 8: sample width. Y_W = X_W+2 and SUM_W = X_W+4 are derived. Only 8 is verified.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- X  in  X_W  input sample
- in_valid  in  1  X is valid
- in_ready  out  1  block accepts X this cycle
- Y  out  Y_W  result
- out_valid  out  1  Y is valid
- out_ready  in  1  consumer takes Y this cycle
- flush  in  1  present only with CS_SEQ_FLUSH_EN

## Operation
- State machine:
  - IDLE: in_ready=1.
  - SCAN: 9 cycles, idx 0..8.
  - DONE: out_valid=1.
- Accept:
  - A sample is accepted when in_valid & in_ready.
  - On accept: sum <= sum - win[wr_ptr] + X; win[wr_ptr] <= X; wr_ptr wraps 8 -> 0; count saturates at 9.
  - If count was already 8 or 9, go to SCAN with idx=0 and xappr=0. Otherwise stay in IDLE (fill phase, no output).
- SCAN, per cycle:
  - If 9*win[idx] <= sum and win[idx] > xappr, then xappr <= win[idx].
  - This is "largest Xi <= floor(sum/9)" computed without a divider.
  - After idx 8, Y <= (sum + 9*xappr_final) >> 3, truncated. The maximum result is 573, so it fits 10 bits.
  - Then go to DONE.
- DONE:
  - Y and out_valid are held until out_ready.
  - On out_ready: out_valid <= 0, go to IDLE.
- in_ready = (state==IDLE) and, when configured, !flush. It is combinational from state.
- Window slots reset to 0, so the slot being replaced during fill contributes 0 to the sum.
- Sum width 12 bits. The 9*win product is 12 bits, formed as (w<<3)+w. No overflow is possible.

## Timing
- Reset values: Y=0, out_valid=0, in_ready=1 (IDLE), sum=0, count=0, wr_ptr=0, all win=0, xappr=0.
- Latency:
  - Accept edge E0 (window full after it).
  - Scan edges E1..E9; E9 registers Y and sets out_valid.
  - out_valid is high in the cycle after E9.
- Throughput: with out_ready held high, at most 1 sample per 11 cycles.
- Backpressure:
  - In SCAN and DONE, in_ready=0 and samples are not consumed; the producer holds X/in_valid.
  - Y is stable while out_valid & !out_ready.
- Reset is asynchronous and may occur mid-SCAN or mid-DONE. All state returns to reset values immediately, and the partial result is discarded.
- out_ready asserted outside DONE is ignored.

## Configuration
- CS_SEQ_FLUSH_EN defined:
  - Adds the flush input.
  - flush=1 at an edge: count, sum, wr_ptr, all win <= 0, out_valid <= 0, state <= IDLE, from any state.
  - A sample presented in the same cycle is not accepted (in_ready=0); flush wins over out_ready.
  - The next 9 accepted samples refill the window before output resumes.
- Undefined: no flush port. The window is cleared only by reset.

## Structure
- Package cs_pkg holds:
  - X_W, WIN=9, Y_W, SUM_W constants.
  - state enum {IDLE, SCAN, DONE}.
  - Index type for 0..8.
- One sub-module, cs_window: 9x8 circular register file, wr_ptr, count, running sum, and a read port at idx.
- cs_seq holds the FSM, scan comparator, xappr register and output register.

## Test plan
- Reset, then accept 1,2,...,9 with out_ready=1:
  - No out_valid during fill.
  - Y=0x00B (sum 45, xappr 5) 9 cycles after the 9th accept.
- Continue with sample 10: window 2..10, Y=0x00D (sum 54, xappr 6).
- Nine samples of 0xFF: Y=0x23D. Nine samples of 0x10: Y=0x024.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid.
  - Y stays stable and in_ready stays 0.
  - Accept on the 6th cycle, then IDLE with in_ready=1 the next cycle.
- Assert reset at SCAN idx 4:
  - Outputs go to reset values immediately.
  - 9 new samples are required before the next Y.
- With CS_SEQ_FLUSH_EN:
  - Assert flush together with in_valid in DONE.
  - The sample is not accepted and out_valid drops.
  - The next 8 accepts produce no output; the 9th does.
